mult_mem_scheduler: RTL and testbench

Shares one multiply datapath (register file + multiplier + result RAM) between two requesters. Arbitrates round-robin and latches the winner's operand addresses and RAM slot. Sequences the datapath through load-A, load-B, multiply, RAM write and RAM read, then returns the RAM read-back value with a one-cycle done pulse. Sits between requester logic and the datapath's control inputs.

---
 rtl/mult_mem_scheduler.sv | 156 +++++++++++++++
 tb/tb_mult_mem_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_mem_scheduler.sv
// Round-robin scheduler sharing one register-file/multiplier/RAM datapath
// between two requesters; sequences load, multiply, write and read-back.
module mult_mem_scheduler #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 16,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] a0_adr,
  input  logic [ADDR_W-1:0] b0_adr,
  input  logic [ADDR_W-1:0] w0_adr,
  input  logic [ADDR_W-1:0] a1_adr,
  input  logic [ADDR_W-1:0] b1_adr,
  input  logic [ADDR_W-1:0] w1_adr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              w_rf,
  output logic [ADDR_W-1:0] rf_adr,
  output logic              DA,
  output logic              SA,
  output logic              SB,
  output logic              w_ram_en,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [2:0]        st_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    LOAD_A = 3'b001,
    LOAD_B = 3'b010,
    MULT   = 3'b011,
    WRITE  = 3'b100,
    READ   = 3'b101,
    RESP   = 3'b110
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] w;
    logic              id;
  } job_t;

  state_t     state, nxt;
  job_t       job;
  logic       last;
  logic       win;
  logic [3:0] cnt;
  logic       mul_end;

  assign mul_end = (cnt == 4'(MUL_LAT - 1));

  // last=1 after reset so requester 0 is preferred first
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req == 2'b11): win = ~last;
      (req == 2'b10): win = 1'b1;
      default:        win = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job    <= '0;
      last   <= 1'b1;
      cnt    <= '0;
      result <= '0;
    end else begin
      if (state == IDLE && req != 2'b00) begin
        job.a  <= win ? a1_adr : a0_adr;
        job.b  <= win ? b1_adr : b0_adr;
        job.w  <= win ? w1_adr : w0_adr;
        job.id <= win;
        last   <= win;
      end
      if (state == LOAD_B)    cnt <= '0;
      else if (state == MULT) cnt <= cnt + 4'd1;
      if (state == READ) result <= ram_rdata;
    end
  end

  always_comb begin
    nxt      = state;
    gnt      = 2'b00;
    done     = 2'b00;
    busy     = 1'b0;
    w_rf     = 1'b0;
    rf_adr   = '0;
    DA       = 1'b0;
    SA       = 1'b0;
    SB       = 1'b0;
    w_ram_en = 1'b0;
    ram_adr  = '0;
    st_out   = state;
    case (state)
      IDLE: begin
        if (req != 2'b00) nxt = LOAD_A;
      end
      LOAD_A: begin
        busy   = 1'b1;
        w_rf   = 1'b1;
        rf_adr = job.a;
        SB     = 1'b1;
        gnt    = job.id ? 2'b10 : 2'b01;
        nxt    = LOAD_B;
      end
      LOAD_B: begin
        busy   = 1'b1;
        w_rf   = 1'b1;
        rf_adr = job.b;
        DA     = 1'b1;
        SA     = 1'b1;
        nxt    = MULT;
      end
      MULT: begin
        busy = 1'b1;
        SA   = 1'b1;
        if (mul_end) nxt = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        SA       = 1'b1;
        w_ram_en = 1'b1;
        ram_adr  = job.w;
        nxt      = READ;
      end
      READ: begin
        busy    = 1'b1;
        SA      = 1'b1;
        ram_adr = job.w;
        nxt     = RESP;
      end
      RESP: begin
        busy = 1'b1;
        done = job.id ? 2'b10 : 2'b01;
        nxt  = IDLE;
      end
      default: begin
        st_out = 3'b000;
        nxt    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_mem_scheduler.sv
// Directed bench for mult_mem_scheduler: MUL_LAT=1 and MUL_LAT=3 builds
// driven from the same stimulus, checked against hand-derived cycles.
module tb_mult_mem_scheduler;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk, rst;
  logic [1:0]    req;
  logic [AW-1:0] a0, b0, w0, a1, b1, w1;
  logic [DW-1:0] rdata;

  logic [1:0]    gnt, done;
  logic [DW-1:0] result;
  logic          busy, w_rf, DA, SA, SB, w_ram_en;
  logic [AW-1:0] rf_adr, ram_adr;
  logic [2:0]    st;

  logic [1:0]    gnt3, done3;
  logic [DW-1:0] result3;
  logic          busy3, w_rf3, DA3, SA3, SB3, w_ram_en3;
  logic [AW-1:0] rf_adr3, ram_adr3;
  logic [2:0]    st3;

  int errs;
  int checks;

  mult_mem_scheduler #(.ADDR_W(AW), .DATA_W(DW), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0_adr(a0), .b0_adr(b0), .w0_adr(w0),
    .a1_adr(a1), .b1_adr(b1), .w1_adr(w1),
    .ram_rdata(rdata),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .w_rf(w_rf), .rf_adr(rf_adr), .DA(DA), .SA(SA), .SB(SB),
    .w_ram_en(w_ram_en), .ram_adr(ram_adr), .st_out(st)
  );

  mult_mem_scheduler #(.ADDR_W(AW), .DATA_W(DW), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req),
    .a0_adr(a0), .b0_adr(b0), .w0_adr(w0),
    .a1_adr(a1), .b1_adr(b1), .w1_adr(w1),
    .ram_rdata(rdata),
    .gnt(gnt3), .done(done3), .result(result3), .busy(busy3),
    .w_rf(w_rf3), .rf_adr(rf_adr3), .DA(DA3), .SA(SA3), .SB(SB3),
    .w_ram_en(w_ram_en3), .ram_adr(ram_adr3), .st_out(st3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 2'b00;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    errs = 0; checks = 0;
    rst = 1'b1; req = 2'b00;
    a0 = '0; b0 = '0; w0 = '0;
    a1 = 3'd6; b1 = 3'd7; w1 = 3'd1;
    rdata = '0;

    // reset state
    do_reset();
    chk("rst st", st, 0);
    chk("rst gnt", gnt, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst busy", busy, 0);
    chk("rst w_rf", w_rf, 0);
    chk("rst ram_adr", ram_adr, 0);

    // single job from requester 0
    req = 2'b01; a0 = 3'd2; b0 = 3'd3; w0 = 3'd5; rdata = 16'h0006;
    tick();
    chk("t1 gnt", gnt, 2'b01);
    chk("t1 st1", st, 1);
    chk("t1 wrf1", w_rf, 1);
    chk("t1 rfa", rf_adr, 2);
    chk("t1 SB", SB, 1);
    chk("t1 busy", busy, 1);
    tick();
    chk("t1 wrf2", w_rf, 1);
    chk("t1 rfb", rf_adr, 3);
    chk("t1 DA", DA, 1);
    chk("t1 gnt off", gnt, 0);
    tick();
    chk("t1 st mult", st, 3);
    chk("t1 wrf off", w_rf, 0);
    tick();
    chk("t1 wram", w_ram_en, 1);
    chk("t1 ram_adr", ram_adr, 5);
    tick();
    chk("t1 st read", st, 5);
    chk("t1 wram off", w_ram_en, 0);
    tick();
    chk("t1 done", done, 2'b01);
    chk("t1 result", result, 16'h0006);
    chk("t1 gnt@done", gnt, 0);
    req = 2'b00;
    tick();
    chk("t1 idle", st, 0);
    chk("t1 idle busy", busy, 0);

    // both request: alternate 0, 1, 0
    do_reset();
    req = 2'b11; a0 = 3'd1; b0 = 3'd1; w0 = 3'd0;
    tick();
    chk("t2 gnt0", gnt, 2'b01);
    tick(5);
    chk("t2 done0", done, 2'b01);
    tick();
    chk("t2 idle", st, 0);
    req = 2'b10;
    tick();
    chk("t2 gnt1", gnt, 2'b10);
    req = 2'b11;
    tick(5);
    chk("t2 done1", done, 2'b10);
    chk("t2 no gnt", gnt, 0);
    tick(2);
    chk("t2 gnt0 again", gnt, 2'b01);
    tick(5);
    chk("t2 done0 again", done, 2'b01);
    req = 2'b00;

    // requester 1 alone, back-to-back grants 7 cycles apart
    do_reset();
    req = 2'b10;
    tick();
    chk("t3 gnt a", gnt, 2'b10);
    tick(6);
    chk("t3 idle gap", st, 0);
    chk("t3 gap gnt", gnt, 0);
    tick();
    chk("t3 gnt b", gnt, 2'b10);
    tick(7);
    chk("t3 gnt c", gnt, 2'b10);
    tick(5);
    chk("t3 done c", done, 2'b10);
    req = 2'b00;

    // reset during MULT
    do_reset();
    req = 2'b01; a0 = 3'd4; b0 = 3'd5; w0 = 3'd3; rdata = 16'h00AA;
    tick(3);
    chk("t4 in mult", st, 3);
    rst = 1'b1;
    #1;
    chk("t4 st", st, 0);
    chk("t4 busy", busy, 0);
    chk("t4 SA", SA, 0);
    tick();
    chk("t4 wram", w_ram_en, 0);
    chk("t4 done", done, 0);
    rst = 1'b0;
    tick();
    chk("t4 regrant", gnt, 2'b01);
    tick(3);
    chk("t4 ram_adr", ram_adr, 3);
    tick(2);
    chk("t4 done new", done, 2'b01);
    chk("t4 result", result, 16'h00AA);
    req = 2'b00;

    // MUL_LAT=3 build
    do_reset();
    req = 2'b01;
    tick(3);
    chk("t5 mult c3", st3, 3);
    tick();
    chk("t5 mult c4", st3, 3);
    tick();
    chk("t5 mult c5", st3, 3);
    tick();
    chk("t5 write c6", st3, 4);
    tick();
    chk("t5 no done c7", done3, 0);
    tick();
    chk("t5 done c8", done3, 2'b01);
    req = 2'b00;

    // drop req and change addresses mid-job
    do_reset();
    req = 2'b01; a0 = 3'd1; b0 = 3'd4; w0 = 3'd6; rdata = 16'h1234;
    tick();
    chk("t6 rfa", rf_adr, 1);
    tick();
    chk("t6 rfb", rf_adr, 4);
    req = 2'b00;
    tick();
    a0 = 3'd7; w0 = 3'd2;
    tick();
    chk("t6 wram", w_ram_en, 1);
    chk("t6 ram_adr w", ram_adr, 6);
    tick();
    chk("t6 ram_adr r", ram_adr, 6);
    tick();
    chk("t6 done", done, 2'b01);
    chk("t6 result", result, 16'h1234);
    tick(2);
    chk("t6 stays idle", st, 0);
    chk("t6 no gnt", gnt, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
